mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous unified memory between the pipeline's instruction-fetch stage and its MEM (load/store) stage.
- Each cycle it grants at most one requester. Data accesses have priority, with a bounded-starvation rule that protects fetch.
- It tags every issued read so the response is routed back to its owner, and it drops in-flight fetch responses on a taken-branch flush.
- Its stall outputs feed the pipeline-register stall inputs and the PC hold.

Parameters:
- ADDR_WIDTH, 32, memory address width in bits.
- DATA_WIDTH, 32, data width in bits.
- MEM_LATENCY, 1, cycles from issue (mem_en high) to mem_rdata valid; legal range 1..4.
- STARVE_LIMIT, 3, maximum consecutive data grants while if_req is pending before fetch is forced; legal range 1..15.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- if_req  in  1  fetch read request
- if_addr  in  ADDR_WIDTH  fetch address (PC)
- if_flush  in  1  taken branch/jump: discard outstanding fetch responses
- if_gnt  out  1  fetch request issued this cycle
- if_stall  out  1  if_req & ~if_gnt
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_WIDTH  fetch read data
- dm_req  in  1  data request
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  store data
- dm_gnt  out  1  data request issued this cycle
- dm_stall  out  1  dm_req & ~dm_gnt
- dm_rvalid  out  1  load data valid
- dm_rdata  out  DATA_WIDTH  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after issue

Behaviour:
- Reset (asynchronous): starve counter = 0; tag pipeline cleared; all registered outputs 0.
  - Combinational outputs evaluate to 0 whenever requests are low.
  - Reset mid-operation discards all in-flight responses; no rvalid appears after reset deasserts.
- Grant selection (combinational, same cycle):
  - Only dm_req: grant data.
  - Only if_req: grant fetch.
  - Both requested: grant data, unless starve_cnt == STARVE_LIMIT, in which case grant fetch.
  - if_gnt and dm_gnt are mutually exclusive.
- Memory drive:
  - mem_en = if_gnt | dm_gnt.
  - mem_we = dm_gnt & dm_we.
  - mem_addr and mem_wdata are muxed from the granted requester.
  - mem_wdata = 0 when no store is granted.
- Starve counter (4-bit):
  - Increments when dm_gnt and if_req are both high.
  - Clears on if_gnt or when if_req is low.
  - Saturates at STARVE_LIMIT.
- Tag pipeline: shift register of depth MEM_LATENCY; each entry is {valid, owner}.
  - Stage 0 is loaded with valid = 1 for a fetch read or a load; stores load valid = 0.
  - On if_flush, every entry with owner = fetch is cleared, including the entry being loaded in the flush cycle.
- Response routing at the pipeline tail:
  - valid & owner = fetch: if_rvalid = 1, if_rdata = mem_rdata.
  - valid & owner = data: dm_rvalid = 1, dm_rdata = mem_rdata.
  - rdata outputs are 0 when the matching rvalid is 0.
- Throughput and latency: one issue per cycle; response latency exactly MEM_LATENCY; responses in order.
- Simultaneous events:
  - if_flush in the cycle a fetch response exits: that response is suppressed.
  - if_flush never affects data entries.
- Writes never produce rvalid.

Decomposition:
- Shared package pkg_mem_arb:
  - owner encoding: OWN_IF = 0, OWN_DM = 1.
  - tag struct {valid, owner}.
  - MAX_LATENCY = 4.
- One natural sub-module: arb_tag_pipe, the parameterised tag shift register with selective owner clear. Grant logic and starve counter stay in the top level.

Test Plan:
- Reset, then if_req = 1, if_addr = 0x10, with mem_rdata model returning 0xAAAA0010 -> if_gnt = 1 in the same cycle; if_rvalid = 1 with if_rdata = 0xAAAA0010 exactly MEM_LATENCY cycles later; dm_rvalid stays 0.
- if_req and dm_req (load, addr 0x100) in the same cycle -> dm_gnt = 1, if_stall = 1, mem_addr = 0x100; fetch is granted the next cycle.
- Continuous dm_req with if_req held, STARVE_LIMIT = 3 -> grant sequence D, D, D, F, D, D, D, F.
- Store dm_we = 1, addr 0x200, wdata 0x12345678 -> mem_we = 1, mem_wdata = 0x12345678; no dm_rvalid ever.
- MEM_LATENCY = 2: fetch at cycle t, load at t+1, if_flush at t+1 -> no if_rvalid; dm_rvalid at t+3.
- Reset asserted one cycle after a fetch issue -> all outputs 0 immediately; no if_rvalid after release.

Source files
------------

// File: rtl/pkg_mem_arb.sv
// Shared types for the fetch/data memory port arbiter.
// Owner encoding and the per-issue tag that travels with each read.
package pkg_mem_arb;

    localparam int MAX_LATENCY = 4;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

endpackage

// File: rtl/arb_tag_pipe.sv
// Tag shift register tracking outstanding reads until their data returns.
// A flush invalidates fetch-owned tags, including the one entering and the one leaving.
module arb_tag_pipe
    import pkg_mem_arb::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clock,
    input  logic reset,
    input  tag_t load_tag,
    input  logic flush,
    output tag_t tail_tag
);

    tag_t stage_q [DEPTH];
    tag_t stage_d [DEPTH];

    always_comb begin
        stage_d[0] = load_tag;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (stage_d[i].owner == OWN_IF) begin
                    stage_d[i].valid = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    // The exiting fetch response is killed in the same cycle as the flush.
    always_comb begin
        tail_tag = stage_q[DEPTH-1];
        if (flush && tail_tag.owner == OWN_IF) begin
            tail_tag.valid = 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port unified memory between fetch and load/store.
// Data wins ties unless fetch has been starved STARVE_LIMIT times in a row.
module mem_port_arbiter
    import pkg_mem_arb::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  if_flush,
    output logic                  if_gnt,
    output logic                  if_stall,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_gnt,
    output logic                  dm_stall,
    output logic                  dm_rvalid,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_q;
    logic [3:0] starve_d;
    logic       starved;
    tag_t       load_tag;
    tag_t       tail_tag;

    assign starved = (starve_q == LIMIT);

    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (dm_req && !(if_req && starved)) begin
            dm_gnt = 1'b1;
        end else if (if_req) begin
            if_gnt = 1'b1;
        end
    end

    assign if_stall = if_req & ~if_gnt;
    assign dm_stall = dm_req & ~dm_gnt;

    assign mem_en    = if_gnt | dm_gnt;
    assign mem_we    = dm_gnt & dm_we;
    assign mem_wdata = mem_we ? dm_wdata : '0;

    always_comb begin
        mem_addr = '0;
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (dm_gnt) begin
            mem_addr = dm_addr;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (if_gnt || !if_req) begin
            starve_d = '0;
        end else if (dm_gnt && !starved) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // Stores occupy a slot but never return data.
    always_comb begin
        load_tag.valid = if_gnt | (dm_gnt & ~dm_we);
        load_tag.owner = dm_gnt ? OWN_DM : OWN_IF;
    end

    arb_tag_pipe #(
        .DEPTH(MEM_LATENCY)
    ) u_tag_pipe (
        .clock   (clock),
        .reset   (reset),
        .load_tag(load_tag),
        .flush   (if_flush),
        .tail_tag(tail_tag)
    );

    assign if_rvalid = tail_tag.valid & (tail_tag.owner == OWN_IF);
    assign dm_rvalid = tail_tag.valid & (tail_tag.owner == OWN_DM);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency-1 and latency-2 instances.
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset;

    logic        if_req, if_flush, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic        if_gnt, if_stall, if_rvalid, dm_gnt, dm_stall, dm_rvalid;
    logic        mem_en, mem_we;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        b_if_req, b_if_flush, b_dm_req, b_dm_we;
    logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata;
    logic        b_if_gnt, b_if_stall, b_if_rvalid, b_dm_gnt, b_dm_stall;
    logic        b_dm_rvalid, b_mem_en, b_mem_we;
    logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata;
    logic [31:0] b_mem_rdata, b_s1;

    int n_checks;
    int n_fail;

    mem_port_arbiter #(
        .MEM_LATENCY (1),
        .STARVE_LIMIT(3)
    ) dut_a (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_stall(if_stall),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_stall(dm_stall),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(
        .MEM_LATENCY (2),
        .STARVE_LIMIT(3)
    ) dut_b (
        .clock(clock), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_flush(b_if_flush),
        .if_gnt(b_if_gnt), .if_stall(b_if_stall),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr),
        .dm_wdata(b_dm_wdata), .dm_gnt(b_dm_gnt), .dm_stall(b_dm_stall),
        .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory models: read data is 0xAAAA concatenated with the low address half.
    always @(posedge clock) begin
        mem_rdata   <= {16'hAAAA, mem_addr[15:0]};
        b_s1        <= {16'hAAAA, b_mem_addr[15:0]};
        b_mem_rdata <= b_s1;
    end

    task automatic idle_inputs();
        if_req = 0; if_flush = 0; dm_req = 0; dm_we = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0;
        b_if_req = 0; b_if_flush = 0; b_dm_req = 0; b_dm_we = 0;
        b_if_addr = 0; b_dm_addr = 0; b_dm_wdata = 0;
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        #1;
        n_checks++;
        if ({if_gnt, dm_gnt, mem_en, mem_we} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b exp 0000",
                     {if_gnt, dm_gnt, mem_en, mem_we});
        end
        n_checks++;
        if ({if_rvalid, dm_rvalid, if_stall, dm_stall} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_resp got %b exp 0000",
                     {if_rvalid, dm_rvalid, if_stall, dm_stall});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data got %h exp 0",
                     {mem_addr, mem_wdata, if_rdata, dm_rdata});
        end
        step();
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        step();
        if_req = 1; if_addr = 32'h10;
        #1;
        n_checks++;
        if ({if_gnt, dm_gnt, mem_en, if_stall} !== 4'b1010) begin
            n_fail++;
            $display("FAIL fetch_gnt got %b exp 1010",
                     {if_gnt, dm_gnt, mem_en, if_stall});
        end
        n_checks++;
        if (mem_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL fetch_addr got %h exp 00000010", mem_addr);
        end
        step();
        if_req = 0;
        #1;
        n_checks++;
        if ({if_rvalid, dm_rvalid} !== 2'b10) begin
            n_fail++;
            $display("FAIL fetch_rvalid got %b exp 10",
                     {if_rvalid, dm_rvalid});
        end
        n_checks++;
        if (if_rdata !== 32'hAAAA0010) begin
            n_fail++;
            $display("FAIL fetch_rdata got %h exp aaaa0010", if_rdata);
        end
        step();
        #1;
        n_checks++;
        if ({if_rvalid, if_rdata} !== 33'h0) begin
            n_fail++;
            $display("FAIL fetch_after got %b/%h exp 0/0",
                     if_rvalid, if_rdata);
        end
    endtask

    task automatic test_priority();
        step();
        if_req = 1; if_addr = 32'h20;
        dm_req = 1; dm_we = 0; dm_addr = 32'h100;
        #1;
        n_checks++;
        if ({dm_gnt, if_gnt, if_stall, dm_stall} !== 4'b1010) begin
            n_fail++;
            $display("FAIL prio_gnt got %b exp 1010",
                     {dm_gnt, if_gnt, if_stall, dm_stall});
        end
        n_checks++;
        if (mem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL prio_addr got %h exp 00000100", mem_addr);
        end
        step();
        dm_req = 0;
        #1;
        n_checks++;
        if ({if_gnt, mem_addr} !== {1'b1, 32'h20}) begin
            n_fail++;
            $display("FAIL prio_fetch_next got %b/%h exp 1/00000020",
                     if_gnt, mem_addr);
        end
        n_checks++;
        if ({dm_rvalid, dm_rdata, if_rvalid} !== {1'b1, 32'hAAAA0100, 1'b0}) begin
            n_fail++;
            $display("FAIL prio_load_resp got %b/%h/%b exp 1/aaaa0100/0",
                     dm_rvalid, dm_rdata, if_rvalid);
        end
        step();
        if_req = 0;
        #1;
        n_checks++;
        if ({if_rvalid, if_rdata} !== {1'b1, 32'hAAAA0020}) begin
            n_fail++;
            $display("FAIL prio_fetch_resp got %b/%h exp 1/aaaa0020",
                     if_rvalid, if_rdata);
        end
    endtask

    task automatic test_starve();
        logic [1:0] exp;
        step();
        if_req = 1; if_addr = 32'h40;
        dm_req = 1; dm_we = 0; dm_addr = 32'h300;
        for (int i = 0; i < 8; i++) begin
            exp = (i % 4 == 3) ? 2'b10 : 2'b01;
            #1;
            n_checks++;
            if ({if_gnt, dm_gnt} !== exp) begin
                n_fail++;
                $display("FAIL starve_seq[%0d] got %b exp %b",
                         i, {if_gnt, dm_gnt}, exp);
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_store();
        step();
        dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'h12345678;
        #1;
        n_checks++;
        if ({dm_gnt, mem_en, mem_we} !== 3'b111) begin
            n_fail++;
            $display("FAIL store_ctrl got %b exp 111",
                     {dm_gnt, mem_en, mem_we});
        end
        n_checks++;
        if ({mem_addr, mem_wdata} !== {32'h200, 32'h12345678}) begin
            n_fail++;
            $display("FAIL store_data got %h/%h exp 00000200/12345678",
                     mem_addr, mem_wdata);
        end
        step();
        dm_we = 0; dm_addr = 32'h204;
        #1;
        n_checks++;
        if ({mem_we, mem_wdata} !== 33'h0) begin
            n_fail++;
            $display("FAIL load_wdata got %b/%h exp 0/0", mem_we, mem_wdata);
        end
        n_checks++;
        if (dm_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL store_no_rvalid got %b exp 0", dm_rvalid);
        end
        step();
        idle_inputs();
        #1;
        n_checks++;
        if ({dm_rvalid, dm_rdata} !== {1'b1, 32'hAAAA0204}) begin
            n_fail++;
            $display("FAIL load_after_store got %b/%h exp 1/aaaa0204",
                     dm_rvalid, dm_rdata);
        end
    endtask

    task automatic test_reset_mid();
        step();
        if_req = 1; if_addr = 32'h40;
        step();
        if_req = 0;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({if_rvalid, dm_rvalid, mem_en, if_rdata} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_mid got %b/%b/%b/%h exp 0/0/0/0",
                     if_rvalid, dm_rvalid, mem_en, if_rdata);
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            #1;
            n_checks++;
            if ({if_rvalid, dm_rvalid} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_release[%0d] got %b exp 00",
                         i, {if_rvalid, dm_rvalid});
            end
        end
    endtask

    task automatic test_flush_lat2();
        // Fetch at t, load + flush at t+1: fetch response lost, load at t+3.
        step();
        b_if_req = 1; b_if_addr = 32'h50;
        step();
        b_if_req = 0; b_if_flush = 1;
        b_dm_req = 1; b_dm_we = 0; b_dm_addr = 32'h140;
        #1;
        n_checks++;
        if ({b_dm_gnt, b_if_rvalid} !== 2'b10) begin
            n_fail++;
            $display("FAIL flush_t1 got %b exp 10", {b_dm_gnt, b_if_rvalid});
        end
        step();
        b_if_flush = 0; b_dm_req = 0;
        #1;
        n_checks++;
        if ({b_if_rvalid, b_dm_rvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_t2 got %b exp 00", {b_if_rvalid, b_dm_rvalid});
        end
        step();
        #1;
        n_checks++;
        if ({b_dm_rvalid, b_dm_rdata, b_if_rvalid} !== {1'b1, 32'hAAAA0140, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_t3 got %b/%h/%b exp 1/aaaa0140/0",
                     b_dm_rvalid, b_dm_rdata, b_if_rvalid);
        end
        // Unflushed fetch returns two cycles after issue.
        step();
        b_if_req = 1; b_if_addr = 32'h60;
        step();
        b_if_req = 0;
        #1;
        n_checks++;
        if (b_if_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL lat2_early got %b exp 0", b_if_rvalid);
        end
        step();
        #1;
        n_checks++;
        if ({b_if_rvalid, b_if_rdata} !== {1'b1, 32'hAAAA0060}) begin
            n_fail++;
            $display("FAIL lat2_resp got %b/%h exp 1/aaaa0060",
                     b_if_rvalid, b_if_rdata);
        end
        // Flush in the exit cycle suppresses the fetch response.
        step();
        b_if_req = 1; b_if_addr = 32'h70;
        step();
        b_if_req = 0;
        step();
        b_if_flush = 1;
        #1;
        n_checks++;
        if ({b_if_rvalid, b_if_rdata} !== 33'h0) begin
            n_fail++;
            $display("FAIL flush_exit got %b/%h exp 0/0",
                     b_if_rvalid, b_if_rdata);
        end
        step();
        b_if_flush = 0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        idle_inputs();
        test_reset();
        test_fetch();
        test_priority();
        test_starve();
        test_store();
        test_reset_mid();
        test_flush_lat2();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
